// File: rtl/dotprod_pkg.sv
// -----------------------------------------------------------------------------
// dotprod_pkg
//   Shared definitions for the dot-product kernel host driver: the default
//   geometry of the kernel arrays, the driver state encoding and the signed
//   element/accumulator types used by the driver and its environment.
// -----------------------------------------------------------------------------
package dotprod_pkg;

   localparam int ADDR_W = 10;    // kernel array address width
   localparam int DATA_W = 27;    // signed element width of arr_a/arr_b
   localparam int ACC_W  = 64;    // signed accumulator/result width
   localparam int DEPTH  = 1000;  // kernel loop bound (addresses 0..DEPTH-1)

   typedef enum logic [2:0] {
      LOAD,   // accepting operand beats from the host
      FILL,   // zero-filling the unused tail of both arrays
      START,  // one cycle with the array ports released, counter cleared
      RUN,    // kernel running, waiting for w_enable or timeout
      DONE    // result presented on the output channel
   } state_t;

   typedef logic signed [DATA_W-1:0] elem_t;
   typedef logic signed [ACC_W-1:0]  acc_t;

endpackage

// File: rtl/dotprod_host_driver.sv
// -----------------------------------------------------------------------------
// dotprod_host_driver
//   Host-side driver for one dot-product kernel instance. Operand pairs arrive
//   on a valid/ready stream and are written into the kernel's arr_a/arr_b; the
//   unused tail is zero-filled, the kernel is released, and its 64-bit result
//   (or a timeout error) is returned on a valid/ready output channel.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           operand beat handshake
//   in_a, in_b, in_last         signed operands, end-of-vector marker
//   out_valid/out_ready         result handshake
//   out_result, out_error       signed dot product, timeout flag
//   run_cycles                  RUN-state cycle count of the last job
//   busy                        low only when idle in LOAD with nothing loaded
//   k_r_enable                  kernel hold (kernel runs only while low)
//   k_controlArr                driver owns the kernel array ports
//   k_init_i, k_init_acc        kernel loop/accumulator init (tied to 0)
//   k_we_*, k_addr_*, k_wdata_* kernel array write ports
//   k_w_enable, k_result        kernel done flag and result
// -----------------------------------------------------------------------------
module dotprod_host_driver #(
   parameter int ADDR_W  = dotprod_pkg::ADDR_W,
   parameter int DATA_W  = dotprod_pkg::DATA_W,
   parameter int ACC_W   = dotprod_pkg::ACC_W,
   parameter int DEPTH   = dotprod_pkg::DEPTH,
   parameter int TIMEOUT = 8191,
   parameter int CYC_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   // operand stream
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_a,
   input  logic signed [DATA_W-1:0] in_b,
   input  logic                     in_last,
   // result channel
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [ACC_W-1:0]  out_result,
   output logic                     out_error,
   output logic [CYC_W-1:0]         run_cycles,
   output logic                     busy,
   // kernel interface
   output logic                     k_r_enable,
   output logic                     k_controlArr,
   output logic [ADDR_W-1:0]        k_init_i,
   output logic signed [ACC_W-1:0]  k_init_acc,
   output logic                     k_we_a,
   output logic                     k_we_b,
   output logic [ADDR_W-1:0]        k_addr_a,
   output logic [ADDR_W-1:0]        k_addr_b,
   output logic signed [DATA_W-1:0] k_wdata_a,
   output logic signed [DATA_W-1:0] k_wdata_b,
   input  logic                     k_w_enable,
   input  logic signed [ACC_W-1:0]  k_result
);

   import dotprod_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_PTR    = ADDR_W'(DEPTH - 1);
   localparam logic [CYC_W-1:0]  TIMEOUT_CNT = CYC_W'(TIMEOUT);
   localparam logic [CYC_W-1:0]  CNT_MAX     = '1;

   state_t                    state_q, state_d;
   logic [ADDR_W-1:0]         ptr_q, ptr_d;
   logic [CYC_W-1:0]          cnt_q, cnt_d;
   logic signed [ACC_W-1:0]   result_q, result_d;
   logic                      error_q, error_d;

   logic                      accept;
   logic                      ptr_at_last;
   logic                      timed_out;

   // in_ready is gated by rst_n so that nothing is accepted or written into
   // the kernel arrays while reset is held, even though the state is LOAD.
   assign accept      = in_valid && in_ready;
   assign ptr_at_last = (ptr_q == LAST_PTR);
   assign timed_out   = (cnt_q == TIMEOUT_CNT);

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= LOAD;
         ptr_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         error_q  <= error_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every combinational output gets a default before the case so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         // The DEPTH-th beat closes the vector whether or not in_last is set;
         // a vector that fills the array exactly needs no zero-fill.
         LOAD:    if (accept && (in_last || ptr_at_last))
                     state_d = ptr_at_last ? START : FILL;
         FILL:    if (ptr_at_last) state_d = START;
         START:   state_d = RUN;
         RUN:     if (k_w_enable || timed_out) state_d = DONE;
         DONE:    if (out_ready) state_d = LOAD;
         default: state_d = LOAD;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath next values: address pointer, run counter, captured result
   // ---------------------------------------------------------------------------
   always_comb begin
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      error_d  = error_q;
      unique case (state_q)
         LOAD:  if (accept) ptr_d = ptr_q + 1'b1;
         FILL:  ptr_d = ptr_q + 1'b1;
         START: cnt_d = '0;
         RUN: begin
            // Done has priority over a timeout detected in the same cycle.
            // The counter is frozen on exit so run_cycles reports the number
            // of RUN cycles that elapsed before the decision.
            if (k_w_enable) begin
               result_d = k_result;
               error_d  = 1'b0;
            end else if (timed_out) begin
               result_d = '0;
               error_d  = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:  if (out_ready) ptr_d = '0;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      in_ready     = (state_q == LOAD) && rst_n;
      out_valid    = (state_q == DONE);
      busy         = !((state_q == LOAD) && (ptr_q == '0));
      k_r_enable   = (state_q != RUN);
      k_controlArr = (state_q == LOAD) || (state_q == FILL);
      k_we_a       = accept || (state_q == FILL);
      k_we_b       = accept || (state_q == FILL);
      k_wdata_a    = '0;
      k_wdata_b    = '0;
      if (state_q == LOAD) begin
         k_wdata_a = in_a;
         k_wdata_b = in_b;
      end
   end

   assign k_addr_a   = ptr_q;
   assign k_addr_b   = ptr_q;
   assign k_init_i   = '0;
   assign k_init_acc = '0;
   assign out_result = result_q;
   assign out_error  = error_q;
   assign run_cycles = cnt_q;

endmodule

// File: tb/tb_dotprod_host_driver.sv
// -----------------------------------------------------------------------------
// tb_dotprod_host_driver
//   Drives randomized and directed operand vectors into the driver, which sits
//   in front of a behavioural dot-product kernel. Expected results are the
//   plain-arithmetic dot product of each issued vector (implicitly zero beyond
//   its length) and are queued at issue time; a monitor pops them whenever a
//   result is handed over. A second driver instance faces a kernel that never
//   finishes, with a short timeout.
// -----------------------------------------------------------------------------
module tb_dotprod_host_driver;
   import dotprod_pkg::*;

   localparam int CYC_W    = 16;
   localparam int KLAT     = 6 * DEPTH + 4;  // kernel latency after release
   localparam int TO_LIMIT = 100;
   localparam int WAIT_MAX = 20000;

   typedef struct {
      acc_t result;
      bit   error;
      int   cycles;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- main DUT signals ----------------
   logic                     in_valid = 1'b0, in_ready, in_last = 1'b0;
   logic signed [DATA_W-1:0] in_a = '0, in_b = '0;
   logic                     out_valid, out_ready, out_error, busy;
   logic signed [ACC_W-1:0]  out_result;
   logic [CYC_W-1:0]         run_cycles;
   logic                     k_r_enable, k_controlArr, k_we_a, k_we_b;
   logic [ADDR_W-1:0]        k_init_i, k_addr_a, k_addr_b;
   logic signed [ACC_W-1:0]  k_init_acc;
   logic signed [DATA_W-1:0] k_wdata_a, k_wdata_b;
   logic                     k_w_enable = 1'b0;
   logic signed [ACC_W-1:0]  k_result = '0;

   // ---------------- timeout DUT signals ----------------
   logic                     t_in_valid = 1'b0, t_in_ready, t_in_last = 1'b0;
   logic signed [DATA_W-1:0] t_in_a = '0, t_in_b = '0;
   logic                     t_out_valid, t_out_ready = 1'b0, t_out_error, t_busy;
   logic signed [ACC_W-1:0]  t_out_result;
   logic [CYC_W-1:0]         t_run_cycles;
   logic                     t_k_r_enable, t_k_controlArr, t_k_we_a, t_k_we_b;
   logic [ADDR_W-1:0]        t_k_init_i, t_k_addr_a, t_k_addr_b;
   logic signed [ACC_W-1:0]  t_k_init_acc;
   logic signed [DATA_W-1:0] t_k_wdata_a, t_k_wdata_b;
   logic                     t_k_w_enable = 1'b0;                 // never finishes
   logic signed [ACC_W-1:0]  t_k_result = 64'sh0123_4567_89AB_CDEF;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   int   ja[$];
   int   jb[$];
   bit   hold_ready = 1'b0;

   dotprod_host_driver #(.TIMEOUT(8191), .CYC_W(CYC_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_error(out_error), .run_cycles(run_cycles), .busy(busy),
      .k_r_enable(k_r_enable), .k_controlArr(k_controlArr),
      .k_init_i(k_init_i), .k_init_acc(k_init_acc),
      .k_we_a(k_we_a), .k_we_b(k_we_b), .k_addr_a(k_addr_a), .k_addr_b(k_addr_b),
      .k_wdata_a(k_wdata_a), .k_wdata_b(k_wdata_b),
      .k_w_enable(k_w_enable), .k_result(k_result)
   );

   dotprod_host_driver #(.TIMEOUT(TO_LIMIT), .CYC_W(CYC_W)) dut_to (
      .clk(clk), .rst_n(rst_n),
      .in_valid(t_in_valid), .in_ready(t_in_ready), .in_a(t_in_a), .in_b(t_in_b), .in_last(t_in_last),
      .out_valid(t_out_valid), .out_ready(t_out_ready), .out_result(t_out_result),
      .out_error(t_out_error), .run_cycles(t_run_cycles), .busy(t_busy),
      .k_r_enable(t_k_r_enable), .k_controlArr(t_k_controlArr),
      .k_init_i(t_k_init_i), .k_init_acc(t_k_init_acc),
      .k_we_a(t_k_we_a), .k_we_b(t_k_we_b), .k_addr_a(t_k_addr_a), .k_addr_b(t_k_addr_b),
      .k_wdata_a(t_k_wdata_a), .k_wdata_b(t_k_wdata_b),
      .k_w_enable(t_k_w_enable), .k_result(t_k_result)
   );

   // ---------------- behavioural kernel ----------------
   // Arrays start with random contents so a missing zero-fill shows up.
   logic signed [DATA_W-1:0] mem_a [DEPTH];
   logic signed [DATA_W-1:0] mem_b [DEPTH];
   bit seeded = 1'b0;
   int kcnt = 0;

   function automatic longint kernel_sum();
      longint acc = 0;
      for (int i = 0; i < DEPTH; i++) acc += longint'(mem_a[i]) * longint'(mem_b[i]);
      return acc;
   endfunction

   always @(posedge clk) begin
      if (!seeded) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] <= DATA_W'($urandom);
            mem_b[i] <= DATA_W'($urandom);
         end
         seeded <= 1'b1;
      end else if (k_controlArr) begin
         if (k_we_a) mem_a[k_addr_a] <= k_wdata_a;
         if (k_we_b) mem_b[k_addr_b] <= k_wdata_b;
      end
      if (k_r_enable) begin
         kcnt       <= 0;
         k_w_enable <= 1'b0;
      end else if (!k_w_enable) begin
         kcnt <= kcnt + 1;
         if (kcnt + 1 == KLAT) begin
            k_w_enable <= 1'b1;
            k_result   <= kernel_sum();
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: actual %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic abort(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired", name);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "bench aborted");
   endtask

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < WAIT_MAX) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) abort("in_ready_wait");
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || !in_ready) && n < WAIT_MAX) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0 || !in_ready) abort("idle_wait");
      @(posedge clk);
      #1;
   endtask

   // Reference: the dot product of the issued vector; entries past its length
   // are zero and contribute nothing.
   task automatic send_job(input bit mark_last, input bit push_exp);
      exp_t e;
      longint acc = 0;
      if (push_exp) begin
         for (int i = 0; i < ja.size(); i++) acc += longint'(ja[i]) * longint'(jb[i]);
         e.result = acc;
         e.error  = 1'b0;
         e.cycles = KLAT;
         exp_q.push_back(e);
      end
      for (int i = 0; i < ja.size(); i++) begin
         while ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         in_valid = 1'b1;
         in_a     = DATA_W'(ja[i]);
         in_b     = DATA_W'(jb[i]);
         in_last  = mark_last && (i == ja.size() - 1);
         wait_ready();
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   function automatic int rand_elem();
      return int'($urandom_range(0, (1 << DATA_W) - 1)) - (1 << (DATA_W - 1));
   endfunction

   task automatic random_job(input int n);
      ja.delete();
      jb.delete();
      for (int i = 0; i < n; i++) begin
         ja.push_back(rand_elem());
         jb.push_back(rand_elem());
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_out_valid"},    out_valid,    0);
      check({tag, "_out_error"},    out_error,    0);
      check({tag, "_out_result"},   out_result,   0);
      check({tag, "_run_cycles"},   run_cycles,   0);
      check({tag, "_k_r_enable"},   k_r_enable,   1);
      check({tag, "_k_controlArr"}, k_controlArr, 1);
      check({tag, "_k_we_a"},       k_we_a,       0);
      check({tag, "_k_we_b"},       k_we_b,       0);
      check({tag, "_busy"},         busy,         0);
   endtask

   // ---------------- output handshake driver ----------------
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         out_ready = hold_ready ? 1'b0 : 1'($urandom_range(0, 1));
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: actual %0d, expected no result", out_result);
         end else begin
            e = exp_q.pop_front();
            check("result",     out_result, e.result);
            check("error",      out_error,  longint'(e.error));
            check("run_cycles", run_cycles, e.cycles);
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      repeat (95000) @(posedge clk);
      abort("global_timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;

      // Reset with in_valid high: nothing may be written during reset.
      in_valid = 1'b1;
      #12;
      check_reset_values("reset");
      check("reset_in_ready", in_ready, 0);
      check("k_init_i", k_init_i, 0);
      check("k_init_acc", k_init_acc, 0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: full-depth vector without in_last, a=i, b=2 -> 999000
      ja.delete();
      jb.delete();
      for (int i = 0; i < DEPTH; i++) begin
         ja.push_back(i);
         jb.push_back(2);
      end
      send_job(1'b0, 1'b1);
      wait_idle();

      // 2: short vector, zero-filled tail -> -74
      ja = '{3, -5, 7};
      jb = '{4, 6, -8};
      send_job(1'b1, 1'b1);
      wait_idle();

      // 3: most negative element squared -> 2**52 (sign extension)
      ja = '{-(1 << (DATA_W - 1))};
      jb = '{-(1 << (DATA_W - 1))};
      send_job(1'b1, 1'b1);
      wait_idle();

      // 4: back-pressure the result for 50 cycles
      hold_ready = 1'b1;
      random_job(5);
      send_job(1'b1, 1'b1);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < WAIT_MAX) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) abort("done_wait");
      for (int i = 0; i < 50; i++) begin
         check("hold_out_valid", out_valid, 1);
         if (exp_q.size() > 0) check("hold_result", out_result, exp_q[0].result);
         check("hold_in_ready", in_ready, 0);
         @(negedge clk);
      end
      hold_ready = 1'b0;
      wait_idle();
      check("idle_busy", busy, 0);

      // 5: reset in the middle of FILL, then a job that must not see stale data
      ja = '{1000000, -1000000, 1000000};
      jb = '{1000000, 1000000, -1000000};
      send_job(1'b1, 1'b0);
      repeat (100) @(posedge clk);
      #3;
      check("fill_busy", busy, 1);
      check("fill_we", k_we_a, 1);
      check("fill_controlArr", k_controlArr, 1);
      rst_n = 1'b0;
      #1;
      check_reset_values("midfill");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      ja = '{1, 1};
      jb = '{1, 1};
      send_job(1'b1, 1'b1);
      wait_idle();

      // Randomized vectors, including one near or at full depth
      random_job($urandom_range(1, 50));
      send_job(1'b1, 1'b1);
      random_job($urandom_range(1, 50));
      send_job(1'b1, 1'b1);
      random_job($urandom_range(DEPTH - 50, DEPTH));
      send_job(1'b1, 1'b1);
      wait_idle();
      check("scoreboard_drained", exp_q.size(), 0);

      // 6: kernel that never finishes, TIMEOUT=100
      t_in_valid = 1'b1;
      t_in_a     = 27'sd5;
      t_in_b     = 27'sd7;
      t_in_last  = 1'b1;
      @(negedge clk);
      check("to_in_ready", t_in_ready, 1);
      @(posedge clk);
      #1;
      t_in_valid = 1'b0;
      t_in_last  = 1'b0;
      n = 0;
      @(negedge clk);
      while (!t_out_valid && n < WAIT_MAX) begin
         @(negedge clk);
         n++;
      end
      if (!t_out_valid) abort("timeout_done_wait");
      check("to_out_error", t_out_error, 1);
      check("to_out_result", t_out_result, 0);
      check("to_run_cycles", t_run_cycles, TO_LIMIT);
      check("to_r_enable", t_k_r_enable, 1);
      t_out_ready = 1'b1;
      @(negedge clk);
      t_out_ready = 1'b0;
      check("to_released_valid", t_out_valid, 0);
      check("to_released_in_ready", t_in_ready, 1);
      check("to_released_busy", t_busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
